alu_decode_stage: RTL and testbench
===================================

Name: alu_decode_stage

Overview:
- Decode/issue stage that produces the ALU's command interface (operand_a, operand_b, alu_op) from RV32I ALU-class instructions: OP, OP-IMM, LUI and AUIPC.
- Sits between fetch and the execute-stage ALU.
- Holds one decoded instruction in a registered output slot with a valid/ready handshake.
- Supports a pipeline flush and keeps a saturating count of illegal instructions.

Parameters:
- CNT_W, 8, width of the saturating illegal-instruction counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- instr_valid  input  1  instr/pc carry a valid instruction.
- instr_ready  output  1  stage can accept an instruction this cycle.
- instr  input  32  instruction word.
- pc  input  32  address of instr.
- rs1_addr  output  5  combinational instr[19:15], to the register file.
- rs2_addr  output  5  combinational instr[24:20], to the register file.
- rs1_data  input  32  same-cycle read data for rs1_addr.
- rs2_data  input  32  same-cycle read data for rs2_addr.
- flush  input  1  discard held and incoming instruction.
- ex_valid  output  1  output slot holds a decoded instruction.
- ex_ready  input  1  execute stage consumes the slot this cycle.
- operand_a  output  32  registered ALU operand A.
- operand_b  output  32  registered ALU operand B.
- alu_op  output  4  registered ALU command. [3:2] selects the unit: 00 arithmetic, 01 logical, 10 shift. [1:0] selects the function within the unit.
- rd_addr  output  5  registered destination register.
- rd_we  output  1  registered write enable.
- illegal  output  1  registered: held instruction is not a supported ALU-class instruction.
- illegal_count  output  CNT_W  saturating count of accepted illegal instructions.

Behaviour:
- Reset: all registered outputs and illegal_count are 0, including ex_valid.
- Handshake:
  - instr_ready = !ex_valid || ex_ready. This is combinational, but is forced to 0 while rst is high.
  - An instruction is accepted when instr_valid && instr_ready && !flush.
  - On accept, the slot loads the decoded fields and ex_valid becomes 1 on the next cycle. Latency is 1 cycle.
  - On ex_ready with no accept, ex_valid becomes 0.
  - Simultaneous consume and accept loads the new entry with ex_valid held at 1. This gives full throughput of 1 instruction per cycle.
  - While ex_valid && !ex_ready, all slot outputs are held stable.
- Flush: next cycle ex_valid = 0. The incoming instruction is dropped and the counter is not updated. Flush has priority over accept and consume. Slot data fields may keep stale values.
- alu_op encoding:
  - ADD 0000, SUB 0001, SLT 0010, SLTU 0011.
  - AND 0100, OR 0101, XOR 0110.
  - SLL 1000, SRL 1001, SRA 1010.
- OP (opcode 0110011): operand_a = rs1_data, operand_b = rs2_data. Decode by funct3/funct7:
  - funct7 = 0000000: 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND.
  - funct7 = 0100000: 000 SUB, 101 SRA.
  - Any other funct7/funct3 combination is illegal.
- OP-IMM (0010011): operand_a = rs1_data.
  - operand_b = sign-extended instr[31:20] for ADDI, SLTI, SLTIU, XORI, ORI, ANDI (same alu_op codes as the OP forms).
  - SLLI requires funct7 = 0. SRLI requires funct7 = 0; SRAI requires funct7 = 0100000. For shifts, operand_b = {27'b0, instr[24:20]}. Any other funct7 on a shift is illegal.
- LUI (0110111): operand_a = 0, operand_b = {instr[31:12], 12'b0}, alu_op = ADD.
- AUIPC (0010111): operand_a = pc, operand_b = {instr[31:12], 12'b0}, alu_op = ADD.
- rd_addr = instr[11:7] always.
- rd_we = legal && (rd_addr != 0).
- Illegal instruction (any other opcode or bad funct field): illegal = 1, rd_we = 0, alu_op = 0000, operand_a = operand_b = 0. The entry still flows through the handshake.
- illegal_count increments by 1 on each accepted illegal instruction and saturates at all-ones with no wrap.
- Reset mid-operation: the held instruction is lost immediately (asynchronous clear). Output is exactly the reset state until the first edge after rst deasserts.

Test Plan:
- Reset then idle: ex_valid = 0, illegal_count = 0, instr_ready = 1. Apply ADD x3,x1,x2 (0x002081B3) with rs1_data = 5, rs2_data = 7 → next cycle ex_valid = 1, alu_op = 0000, operand_a = 5, operand_b = 7, rd_addr = 3, rd_we = 1.
- SRAI x5,x6,4 (0x40435293) → alu_op = 1010, operand_b = 4. ADDI x1,x0,-1 (0xFFF00093) → operand_b = 0xFFFFFFFF, alu_op = 0000.
- AUIPC x2,0x12345 (0x12345117) at pc = 0x100 → operand_a = 0x100, operand_b = 0x12345000, alu_op = 0000. LUI x0,1 (0x00001037) → rd_we = 0.
- Backpressure: hold ex_ready = 0 with ex_valid = 1 → instr_ready = 0 and outputs stable for 3 cycles. Then ex_ready = 1 with a new instruction valid → new entry appears next cycle and ex_valid stays 1.
- Illegal: opcode 0x00000073 → illegal = 1, rd_we = 0, illegal_count = 1. Issue 300 illegal instructions in total → illegal_count = 255. Flush in the same cycle as an illegal instruction → no count and ex_valid = 0 next cycle.
- Assert rst asynchronously while ex_valid = 1 → ex_valid = 0 and all outputs 0 before the next clock edge.

Source files
------------

// File: rtl/alu_decode_stage.sv
// Decode/issue stage for RV32I ALU-class instructions (OP, OP-IMM, LUI, AUIPC).
// Holds one decoded entry in a registered slot with valid/ready handshake.
module alu_decode_stage #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [31:0]      instr,
    input  logic [31:0]      pc,
    output logic [4:0]       rs1_addr,
    output logic [4:0]       rs2_addr,
    input  logic [31:0]      rs1_data,
    input  logic [31:0]      rs2_data,
    input  logic             flush,
    output logic             ex_valid,
    input  logic             ex_ready,
    output logic [31:0]      operand_a,
    output logic [31:0]      operand_b,
    output logic [3:0]       alu_op,
    output logic [4:0]       rd_addr,
    output logic             rd_we,
    output logic             illegal,
    output logic [CNT_W-1:0] illegal_count
);

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] F7_ZERO   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_SLT  = 4'b0010;
    localparam logic [3:0] OP_SLTU = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0100;
    localparam logic [3:0] OP_OR   = 4'b0101;
    localparam logic [3:0] OP_XOR  = 4'b0110;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1010;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i;
    logic [31:0] imm_u;
    logic [31:0] shamt;
    logic [3:0]  base_op;

    logic        d_legal;
    logic [3:0]  d_op;
    logic [31:0] d_a;
    logic [31:0] d_b;
    logic        accept;

    assign opcode   = instr[6:0];
    assign funct3   = instr[14:12];
    assign funct7   = instr[31:25];
    assign imm_i    = {{20{instr[31]}}, instr[31:20]};
    assign imm_u    = {instr[31:12], 12'b0};
    assign shamt    = {27'b0, instr[24:20]};
    assign rs1_addr = instr[19:15];
    assign rs2_addr = instr[24:20];

    // funct3 -> command for the funct7 = 0 forms shared by OP and OP-IMM
    always_comb begin
        base_op = OP_ADD;
        unique case (funct3)
            3'b000: base_op = OP_ADD;
            3'b001: base_op = OP_SLL;
            3'b010: base_op = OP_SLT;
            3'b011: base_op = OP_SLTU;
            3'b100: base_op = OP_XOR;
            3'b101: base_op = OP_SRL;
            3'b110: base_op = OP_OR;
            3'b111: base_op = OP_AND;
            default: base_op = OP_ADD;
        endcase
    end

    always_comb begin
        d_legal = 1'b0;
        d_op    = OP_ADD;
        d_a     = 32'b0;
        d_b     = 32'b0;
        unique case (opcode)
            OPC_OP: begin
                d_a = rs1_data;
                d_b = rs2_data;
                if (funct7 == F7_ZERO) begin
                    d_legal = 1'b1;
                    d_op    = base_op;
                end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
                    d_legal = 1'b1;
                    d_op    = OP_SUB;
                end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
                    d_legal = 1'b1;
                    d_op    = OP_SRA;
                end
            end
            OPC_OPIMM: begin
                d_a = rs1_data;
                if (funct3 == 3'b001) begin
                    d_b     = shamt;
                    d_legal = (funct7 == F7_ZERO);
                    d_op    = OP_SLL;
                end else if (funct3 == 3'b101) begin
                    d_b     = shamt;
                    d_legal = (funct7 == F7_ZERO) || (funct7 == F7_ALT);
                    d_op    = (funct7 == F7_ALT) ? OP_SRA : OP_SRL;
                end else begin
                    d_b     = imm_i;
                    d_legal = 1'b1;
                    d_op    = base_op;
                end
            end
            OPC_LUI: begin
                d_legal = 1'b1;
                d_b     = imm_u;
            end
            OPC_AUIPC: begin
                d_legal = 1'b1;
                d_a     = pc;
                d_b     = imm_u;
            end
            default: d_legal = 1'b0;
        endcase
        // Illegal entries still flow through, but carry a zeroed command
        if (!d_legal) begin
            d_op = OP_ADD;
            d_a  = 32'b0;
            d_b  = 32'b0;
        end
    end

    assign instr_ready = !rst && (!ex_valid || ex_ready);
    assign accept      = instr_valid && instr_ready && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid  <= 1'b0;
            operand_a <= 32'b0;
            operand_b <= 32'b0;
            alu_op    <= 4'b0;
            rd_addr   <= 5'b0;
            rd_we     <= 1'b0;
            illegal   <= 1'b0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (accept) begin
            ex_valid  <= 1'b1;
            operand_a <= d_a;
            operand_b <= d_b;
            alu_op    <= d_op;
            rd_addr   <= instr[11:7];
            rd_we     <= d_legal && (instr[11:7] != 5'd0);
            illegal   <= !d_legal;
        end else if (ex_ready) begin
            ex_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_count <= '0;
        end else if (accept && !d_legal && illegal_count != {CNT_W{1'b1}}) begin
            illegal_count <= illegal_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_alu_decode_stage.sv
// Self-checking bench for alu_decode_stage: directed cases from the
// instruction set rules plus randomized traffic against a behavioural model.
module tb_alu_decode_stage;

    typedef struct packed {
        logic        ill;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } dec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [31:0] instr = 32'b0;
    logic [31:0] pc = 32'b0;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data = 32'b0;
    logic [31:0] rs2_data = 32'b0;
    logic        flush = 1'b0;
    logic        ex_valid;
    logic        ex_ready = 1'b0;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [3:0]  alu_op;
    logic [4:0]  rd_addr;
    logic        rd_we;
    logic        illegal;
    logic [7:0]  illegal_count;

    int checks = 0;
    int errors = 0;

    // behavioural model of the output slot
    logic        m_valid;
    dec_t        m_dec;
    logic [4:0]  m_rd;
    logic        m_we;
    int          m_cnt;

    alu_decode_stage #(.CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .pc(pc),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .flush(flush),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .operand_a(operand_a), .operand_b(operand_b),
        .alu_op(alu_op), .rd_addr(rd_addr), .rd_we(rd_we),
        .illegal(illegal), .illegal_count(illegal_count)
    );

    always #5 clk = ~clk;

    // Mnemonic-level reference: command codes by instruction name
    function automatic dec_t ref_decode(logic [31:0] i, logic [31:0] p,
                                        logic [31:0] r1, logic [31:0] r2);
        logic [3:0] by_f3 [8] = '{4'h0, 4'h8, 4'h2, 4'h3, 4'h6, 4'h9, 4'h5, 4'h4};
        dec_t d;
        logic [2:0] f3;
        logic [6:0] f7;
        f3 = i[14:12];
        f7 = i[31:25];
        d = '{ill: 1'b1, op: 4'h0, a: 32'h0, b: 32'h0};
        case (i[6:0])
            7'h33: begin
                if (f7 == 7'h00) d = '{1'b0, by_f3[f3], r1, r2};
                else if (f7 == 7'h20 && f3 == 3'd0) d = '{1'b0, 4'h1, r1, r2};
                else if (f7 == 7'h20 && f3 == 3'd5) d = '{1'b0, 4'hA, r1, r2};
            end
            7'h13: begin
                if (f3 == 3'd1 || f3 == 3'd5) begin
                    if (f7 == 7'h00)
                        d = '{1'b0, by_f3[f3], r1, 32'(i[24:20])};
                    else if (f7 == 7'h20 && f3 == 3'd5)
                        d = '{1'b0, 4'hA, r1, 32'(i[24:20])};
                end else begin
                    d = '{1'b0, by_f3[f3], r1, 32'($signed(i[31:20]))};
                end
            end
            7'h37: d = '{1'b0, 4'h0, 32'h0, i & 32'hFFFF_F000};
            7'h17: d = '{1'b0, 4'h0, p, i & 32'hFFFF_F000};
            default: ;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [31:0] w;
        logic [6:0]  f7;
        int k;
        w = $urandom;
        k = $urandom_range(0, 9);
        case ($urandom_range(0, 2))
            0: f7 = 7'h00;
            1: f7 = 7'h20;
            default: f7 = 7'($urandom);
        endcase
        if (k <= 2) w = {f7, w[24:7], 7'h33};
        else if (k <= 5) w = (w[13:12] == 2'b01) ? {f7, w[24:7], 7'h13} : {w[31:7], 7'h13};
        else if (k == 6) w = {w[31:7], 7'h37};
        else if (k == 7) w = {w[31:7], 7'h17};
        else if (k == 8) w = {w[31:2], 2'b11};
        return w;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_dec   = '0;
        m_rd    = 5'd0;
        m_we    = 1'b0;
        m_cnt   = 0;
    endtask

    // one clock edge; the model moves with the DUT on the same inputs
    task automatic tick();
        logic acc;
        dec_t d;
        acc = instr_valid && (!m_valid || ex_ready) && !flush && !rst;
        d = ref_decode(instr, pc, rs1_data, rs2_data);
        @(posedge clk);
        if (flush) begin
            m_valid = 1'b0;
        end else if (acc) begin
            m_valid = 1'b1;
            m_dec   = d;
            m_rd    = instr[11:7];
            m_we    = !d.ill && instr[11:7] != 5'd0;
            if (d.ill && m_cnt < 255) m_cnt++;
        end else if (ex_ready) begin
            m_valid = 1'b0;
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        instr_valid = 1'b0;
        flush = 1'b0;
        ex_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (ex_valid !== 1'b0) begin
            errors++; $display("FAIL reset_ex_valid got %0b want 0", ex_valid);
        end
        checks++;
        if (illegal_count !== 8'd0) begin
            errors++; $display("FAIL reset_count got %0d want 0", illegal_count);
        end
        checks++;
        if (instr_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready got %0b want 1", instr_ready);
        end
    endtask

    task automatic test_directed();
        logic [31:0] iw [5] = '{32'h002081B3, 32'h40435293, 32'hFFF00093,
                                32'h12345117, 32'h00001037};
        logic [31:0] ea [5] = '{32'd5, 32'd11, 32'd0, 32'h100, 32'd0};
        logic [31:0] eb [5] = '{32'd7, 32'd4, 32'hFFFF_FFFF, 32'h1234_5000, 32'h1000};
        logic [3:0]  eo [5] = '{4'b0000, 4'b1010, 4'b0000, 4'b0000, 4'b0000};
        logic [4:0]  er [5] = '{5'd3, 5'd5, 5'd1, 5'd2, 5'd0};
        logic        ew [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        ex_ready = 1'b1;
        for (int n = 0; n < 5; n++) begin
            instr = iw[n];
            instr_valid = 1'b1;
            pc = 32'h100;
            rs1_data = (n == 0) ? 32'd5 : (n == 1) ? 32'd11 : 32'd0;
            rs2_data = (n == 0) ? 32'd7 : 32'hDEAD_BEEF;
            tick();
            checks++;
            if ({ex_valid, illegal, alu_op, operand_a, operand_b, rd_addr, rd_we}
                !== {1'b1, 1'b0, eo[n], ea[n], eb[n], er[n], ew[n]}) begin
                errors++;
                $display("FAIL directed_%0d got v=%0b op=%h a=%h b=%h rd=%0d we=%0b want op=%h a=%h b=%h rd=%0d we=%0b",
                         n, ex_valid, alu_op, operand_a, operand_b, rd_addr, rd_we,
                         eo[n], ea[n], eb[n], er[n], ew[n]);
            end
        end
        instr_valid = 1'b0;
        tick();
        checks++;
        if (ex_valid !== 1'b0) begin
            errors++; $display("FAIL drain_ex_valid got %0b want 0", ex_valid);
        end
    endtask

    task automatic test_backpressure();
        ex_ready = 1'b1;
        instr_valid = 1'b1;
        instr = 32'h002081B3;
        rs1_data = 32'd5;
        rs2_data = 32'd7;
        tick();
        ex_ready = 1'b0;
        instr = 32'h0020C233;
        rs1_data = 32'd9;
        rs2_data = 32'd3;
        for (int n = 0; n < 3; n++) begin
            #1;
            checks++;
            if (instr_ready !== 1'b0) begin
                errors++; $display("FAIL bp_ready_%0d got %0b want 0", n, instr_ready);
            end
            tick();
            checks++;
            if ({ex_valid, alu_op, operand_a, operand_b, rd_addr}
                !== {1'b1, 4'h0, 32'd5, 32'd7, 5'd3}) begin
                errors++;
                $display("FAIL bp_hold_%0d got v=%0b op=%h a=%h b=%h rd=%0d want v=1 op=0 a=5 b=7 rd=3",
                         n, ex_valid, alu_op, operand_a, operand_b, rd_addr);
            end
        end
        ex_ready = 1'b1;
        #1;
        checks++;
        if (instr_ready !== 1'b1) begin
            errors++; $display("FAIL bp_release_ready got %0b want 1", instr_ready);
        end
        tick();
        checks++;
        if ({ex_valid, alu_op, operand_a, operand_b, rd_addr}
            !== {1'b1, 4'h6, 32'd9, 32'd3, 5'd4}) begin
            errors++;
            $display("FAIL bp_next got v=%0b op=%h a=%h b=%h rd=%0d want v=1 op=6 a=9 b=3 rd=4",
                     ex_valid, alu_op, operand_a, operand_b, rd_addr);
        end
        instr_valid = 1'b0;
        tick();
    endtask

    task automatic test_illegal();
        do_reset();
        ex_ready = 1'b1;
        instr_valid = 1'b1;
        instr = 32'h0000_0073;
        rs1_data = 32'h1234;
        rs2_data = 32'h5678;
        tick();
        checks++;
        if ({ex_valid, illegal, rd_we, alu_op, operand_a, operand_b, illegal_count}
            !== {1'b1, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 8'd1}) begin
            errors++;
            $display("FAIL illegal_first got v=%0b ill=%0b we=%0b op=%h a=%h b=%h cnt=%0d want 1 1 0 0 0 0 1",
                     ex_valid, illegal, rd_we, alu_op, operand_a, operand_b, illegal_count);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if ({ex_valid, illegal_count} !== {1'b0, 8'd1}) begin
            errors++;
            $display("FAIL flush_illegal got v=%0b cnt=%0d want v=0 cnt=1", ex_valid, illegal_count);
        end
        for (int n = 1; n < 300; n++) begin
            instr = {$urandom_range(0, 1) ? 25'($urandom) : 25'h0, 7'h73};
            tick();
            if (n == 254) begin
                checks++;
                if (illegal_count !== 8'd255) begin
                    errors++; $display("FAIL count_reach got %0d want 255", illegal_count);
                end
            end
        end
        checks++;
        if (illegal_count !== 8'd255) begin
            errors++; $display("FAIL count_saturate got %0d want 255", illegal_count);
        end
        instr_valid = 1'b0;
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 600; n++) begin
            instr       = gen_instr();
            pc          = $urandom & 32'hFFFF_FFFC;
            rs1_data    = $urandom;
            rs2_data    = $urandom;
            instr_valid = ($urandom_range(0, 3) != 0);
            ex_ready    = ($urandom_range(0, 2) != 0);
            flush       = ($urandom_range(0, 15) == 0);
            #1;
            checks++;
            if ({instr_ready, rs1_addr, rs2_addr}
                !== {(!m_valid || ex_ready), instr[19:15], instr[24:20]}) begin
                errors++;
                $display("FAIL rand_comb_%0d got rdy=%0b rs1=%0d rs2=%0d want rdy=%0b rs1=%0d rs2=%0d",
                         n, instr_ready, rs1_addr, rs2_addr,
                         (!m_valid || ex_ready), instr[19:15], instr[24:20]);
            end
            tick();
            checks++;
            if (ex_valid !== m_valid || illegal_count !== 8'(m_cnt)) begin
                errors++;
                $display("FAIL rand_state_%0d got v=%0b cnt=%0d want v=%0b cnt=%0d",
                         n, ex_valid, illegal_count, m_valid, m_cnt);
            end
            if (m_valid) begin
                checks++;
                if ({illegal, alu_op, operand_a, operand_b, rd_addr, rd_we}
                    !== {m_dec.ill, m_dec.op, m_dec.a, m_dec.b, m_rd, m_we}) begin
                    errors++;
                    $display("FAIL rand_slot_%0d got ill=%0b op=%h a=%h b=%h rd=%0d we=%0b want ill=%0b op=%h a=%h b=%h rd=%0d we=%0b",
                             n, illegal, alu_op, operand_a, operand_b, rd_addr, rd_we,
                             m_dec.ill, m_dec.op, m_dec.a, m_dec.b, m_rd, m_we);
                end
            end
        end
        flush = 1'b0;
        instr_valid = 1'b0;
    endtask

    task automatic test_async_reset();
        ex_ready = 1'b1;
        instr_valid = 1'b1;
        instr = 32'h0000_0073;
        tick();
        instr = 32'h002081B3;
        rs1_data = 32'd5;
        rs2_data = 32'd7;
        tick();
        ex_ready = 1'b0;
        instr_valid = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if ({ex_valid, instr_ready, illegal, rd_we, alu_op, operand_a, operand_b, rd_addr, illegal_count}
            !== '0) begin
            errors++;
            $display("FAIL async_reset got v=%0b rdy=%0b ill=%0b we=%0b op=%h a=%h b=%h rd=%0d cnt=%0d want all 0",
                     ex_valid, instr_ready, illegal, rd_we, alu_op, operand_a, operand_b,
                     rd_addr, illegal_count);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({ex_valid, instr_ready} !== 2'b01) begin
            errors++;
            $display("FAIL after_reset got v=%0b rdy=%0b want v=0 rdy=1", ex_valid, instr_ready);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_directed();
        test_backpressure();
        test_illegal();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
